// File: rtl/cam_rgb565_capture_pkg.sv
// Shared definitions for the DVP RGB565 capture stage.
// Contents: RGB565 pixel layout, default frame geometry, capture FSM state
// encoding and the byte-pair packing helper.
package cam_rgb565_capture_pkg;

  // RGB565 layout: R in [15:11], G in [10:5], B in [4:0].
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  // Combine the two bus bytes of one pixel in the order the sensor sends them.
  function automatic rgb565_t rgb_pack(input logic [7:0] first_b,
                                       input logic [7:0] second_b,
                                       input logic       hi_first);
    return hi_first ? {first_b, second_b} : {second_b, first_b};
  endfunction

endpackage

// File: rtl/cam_rgb565_capture_sync_edge_det.sv
// Registers a 1-bit signal and reports its edges against the live value.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_sig    : signal to watch
//   o_d      : i_sig delayed by one clock
//   o_rise   : i_sig & ~o_d
//   o_fall   : o_d & ~i_sig
module cam_rgb565_capture_sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= 1'b0;
    end else begin
      r_d <= i_sig;
    end
  end

  assign o_d    = r_d;
  assign o_rise = i_sig & ~r_d;
  assign o_fall = r_d & ~i_sig;

endmodule

// File: rtl/cam_rgb565_capture.sv
// DVP camera capture: samples vsync/href/data and assembles byte pairs into
// RGB565 pixels with x/y coordinates.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   capture_en                : arm capture, sampled at vsync fall only
//   cam_vsync/cam_href/cam_data : camera bus
//   rgb_out, rgb_valid        : pixel and its one-cycle strobe
//   pix_x, pix_y              : coordinates of rgb_out
//   frame_start, frame_done   : frame boundary pulses
//   line_err                  : pulse after a malformed line
module cam_rgb565_capture
  import cam_rgb565_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned HI_FIRST = 1,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           capture_en,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_data,
  output logic [15:0]    rgb_out,
  output logic           rgb_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_start,
  output logic           frame_done,
  output logic           line_err
);

  // Counters carry one extra bit so over-long lines/frames never wrap back
  // into the valid range.
  localparam logic [X_W:0] H_LIM = (X_W + 1)'(H_ACTIVE);
  localparam logic [Y_W:0] V_LIM = (Y_W + 1)'(V_ACTIVE);

  logic           w_vs_rise, w_vs_fall, w_vs_d;
  logic           w_href_rise, w_href_fall, w_href_d;
  logic           w_unused;
  logic           w_line_bad;
  rgb565_t        w_pix;

  logic [1:0]     r_state;
  logic           r_phase;
  logic [7:0]     r_hold;
  logic [X_W:0]   r_x_cnt;
  logic [Y_W:0]   r_y_cnt;
  rgb565_t        r_rgb;
  logic           r_valid;
  logic [X_W-1:0] r_pix_x;
  logic [Y_W-1:0] r_pix_y;
  logic           r_fs, r_fd, r_le;

  cam_rgb565_capture_sync_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (cam_vsync),
    .o_d    (w_vs_d),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  cam_rgb565_capture_sync_edge_det u_href_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (cam_href),
    .o_d    (w_href_d),
    .o_rise (w_href_rise),
    .o_fall (w_href_fall)
  );

  assign w_unused   = ^{w_vs_d, w_href_rise};
  // A line is good only with an even byte count and exactly H_ACTIVE pixels.
  assign w_line_bad = r_phase | (r_x_cnt != H_LIM);
  assign w_pix      = rgb_pack(r_hold, cam_data, HI_FIRST != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= 1'b0;
      r_hold  <= '0;
      r_x_cnt <= '0;
      r_y_cnt <= '0;
      r_rgb   <= '0;
      r_valid <= 1'b0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
      r_le    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
      r_le    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_phase <= 1'b0;
          if (cam_vsync) r_state <= ST_WAIT_VS;
        end
        ST_WAIT_VS: begin
          r_phase <= 1'b0;
          if (w_vs_fall && capture_en) begin
            r_state <= ST_ACTIVE;
            r_fs    <= 1'b1;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_vs_rise) begin
            // Line still open (or closing this cycle) is judged before the frame ends.
            if (w_href_d) r_le <= w_line_bad;
            r_fd    <= 1'b1;
            r_state <= ST_WAIT_VS;
            r_phase <= 1'b0;
            r_x_cnt <= '0;
          end else if (w_href_fall) begin
            r_le    <= w_line_bad;
            r_phase <= 1'b0;
            r_x_cnt <= '0;
            if (r_y_cnt != V_LIM) r_y_cnt <= r_y_cnt + 1'b1;
          end else if (cam_href) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_hold <= cam_data;
            end else begin
              if (r_x_cnt < H_LIM && r_y_cnt < V_LIM) begin
                r_rgb   <= w_pix;
                r_valid <= 1'b1;
                r_pix_x <= r_x_cnt[X_W-1:0];
                r_pix_y <= r_y_cnt[Y_W-1:0];
              end
              if (r_x_cnt != H_LIM + 1'b1) r_x_cnt <= r_x_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rgb_out     = r_rgb;
  assign rgb_valid   = r_valid;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_fs;
  assign frame_done  = r_fd;
  assign line_err    = r_le;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Directed bench for cam_rgb565_capture with a 4x2 frame, two DUTs sharing
// the bus: one high-byte-first, one low-byte-first.
module tb_cam_rgb565_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;

  logic [15:0] rgb0, rgb1;
  logic        v0, v1;
  logic [2:0]  x0, x1;
  logic [1:0]  y0, y1;
  logic        fs0, fs1, fd0, fd1, le0, le1;

  always #5 clk = ~clk;

  cam_rgb565_capture #(
    .H_ACTIVE (4), .V_ACTIVE (2), .HI_FIRST (1), .X_W (3), .Y_W (2)
  ) u_dut_hi (
    .clk (clk), .rst (rst), .capture_en (capture_en),
    .cam_vsync (cam_vsync), .cam_href (cam_href), .cam_data (cam_data),
    .rgb_out (rgb0), .rgb_valid (v0), .pix_x (x0), .pix_y (y0),
    .frame_start (fs0), .frame_done (fd0), .line_err (le0)
  );

  cam_rgb565_capture #(
    .H_ACTIVE (4), .V_ACTIVE (2), .HI_FIRST (0), .X_W (3), .Y_W (2)
  ) u_dut_lo (
    .clk (clk), .rst (rst), .capture_en (capture_en),
    .cam_vsync (cam_vsync), .cam_href (cam_href), .cam_data (cam_data),
    .rgb_out (rgb1), .rgb_valid (v1), .pix_x (x1), .pix_y (y1),
    .frame_start (fs1), .frame_done (fd1), .line_err (le1)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  x;
    logic [1:0]  y;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
  } exp_pix_t;

  exp_pix_t q[$];
  int n_valid = 0, n_fs = 0, n_fd = 0, n_le = 0;

  // Scoreboard: every strobe must match the next expected pixel.
  always @(negedge clk) begin
    exp_pix_t e;
    if (v0) begin
      n_valid++;
      if (q.size() == 0) begin
        check_val("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check_val("pix_hi", {11'd0, x0, y0, rgb0}, {11'd0, e.x, e.y, e.r_hi});
        check_val("valid_lo", {31'd0, v1}, 32'd1);
        check_val("pix_lo", {11'd0, x1, y1, rgb1}, {11'd0, e.x, e.y, e.r_lo});
      end
    end else if (v1) begin
      check_val("valid_lo_extra", 32'd1, 32'd0);
    end
    if (fs0) n_fs++;
    if (fd0) n_fd++;
    if (le0) n_le++;
    if (fs0 !== fs1 || fd0 !== fd1 || le0 !== le1)
      check_val("ctrl_lo_eq", {29'd0, fs1, fd1, le1}, {29'd0, fs0, fd0, le0});
  end

  int  bf = 0;
  int  bl = 0;
  bit  exp_on = 0;

  function automatic logic [7:0] byte_at(input int f, input int l, input int k);
    if (f == 1 && l == 0 && k == 0) return 8'h86;
    if (f == 1 && l == 0 && k == 1) return 8'h10;
    if (f == 1 && l == 1 && k == 0) return 8'h10;
    if (f == 1 && l == 1 && k == 1) return 8'h86;
    return 8'((f * 64 + l * 16 + k * 5 + 3) & 255);
  endfunction

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(input logic en);
    bf++;
    bl = 0;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    capture_en = en;
    exp_on     = en;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
  endtask

  // Sends nbytes on href; end_vs closes the line with a simultaneous vsync rise.
  task automatic send_line(input int nbytes, input bit end_vs);
    logic [7:0] prev, b;
    exp_pix_t   e;
    prev = 8'h00;
    for (int k = 0; k < nbytes; k++) begin
      b = byte_at(bf, bl, k);
      if ((k % 2) == 1 && exp_on && (k / 2) < 4 && bl < 2) begin
        e.x    = 3'(k / 2);
        e.y    = 2'(bl);
        e.r_hi = {prev, b};
        e.r_lo = {b, prev};
        q.push_back(e);
      end
      cyc(1'b0, 1'b1, b);
      if (bf == 1 && bl == 0 && k == 0) check_val("no_early_valid", {31'd0, v0}, 32'd0);
      if (bf == 1 && bl == 0 && k == 1) begin
        check_val("first_valid", {31'd0, v0}, 32'd1);
        check_val("first_rgb", {16'd0, rgb0}, 32'h8610);
      end
      if (bf == 1 && bl == 1 && k == 1) check_val("lo_first_8610", {16'd0, rgb1}, 32'h8610);
      prev = b;
    end
    if (end_vs) begin
      cyc(1'b1, 1'b0, 8'h00);
    end else begin
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
    end
    bl++;
  endtask

  task automatic check_counts(input string tag, input int bv, input int bs, input int bd,
                              input int be, input int ev, input int es, input int ed,
                              input int ee);
    check_val({tag, "_valids"}, 32'(n_valid - bv), 32'(ev));
    check_val({tag, "_fstart"}, 32'(n_fs - bs), 32'(es));
    check_val({tag, "_fdone"},  32'(n_fd - bd), 32'(ed));
    check_val({tag, "_lerr"},   32'(n_le - be), 32'(ee));
  endtask

  task automatic check_zero(input string tag);
    check_val(tag, {5'd0, v0, x0, y0, rgb0, fs0, fd0, le0}, 32'd0);
  endtask

  initial begin
    int bv, bs, bd, be;
    rst = 1'b1; capture_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_zero("reset_outputs");
    rst = 1'b0;

    // Frame 1: full line, 7-byte line, dropped third line.
    bv = n_valid; bs = n_fs; bd = n_fd; be = n_le;
    bf++; bl = 0;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    capture_en = 1'b1; exp_on = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    check_val("fs_pulse", {31'd0, fs0}, 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("fs_one_cycle", {31'd0, fs0}, 32'd0);
    send_line(8, 1'b0);
    check_counts("f1_l0", bv, bs, bd, be, 4, 1, 0, 0);
    send_line(7, 1'b0);
    check_counts("f1_l1", bv, bs, bd, be, 7, 1, 0, 1);
    send_line(8, 1'b0);
    cyc(1'b1, 1'b0, 8'h00);
    check_val("fd_pulse", {31'd0, fd0}, 32'd1);
    cyc(1'b1, 1'b0, 8'h00);
    check_val("fd_one_cycle", {31'd0, fd0}, 32'd0);
    check_counts("f1", bv, bs, bd, be, 7, 1, 1, 1);

    // Frame 2: 5-pixel line, then a short line closed by vsync rise.
    bv = n_valid; bs = n_fs; bd = n_fd; be = n_le;
    frame_begin(1'b1);
    send_line(10, 1'b0);
    send_line(6, 1'b1);
    cyc(1'b1, 1'b0, 8'h00);
    check_counts("f2", bv, bs, bd, be, 7, 1, 1, 2);

    // Frame 3: capture disabled at vsync fall.
    bv = n_valid; bs = n_fs; bd = n_fd; be = n_le;
    frame_begin(1'b0);
    send_line(8, 1'b0);
    frame_end();
    check_counts("f3_off", bv, bs, bd, be, 0, 0, 0, 0);

    // Frame 4: capture_en dropped mid-frame still completes; frame 5 ignored.
    bv = n_valid; bs = n_fs; bd = n_fd; be = n_le;
    frame_begin(1'b1);
    send_line(8, 1'b0);
    capture_en = 1'b0;
    send_line(8, 1'b0);
    frame_end();
    check_counts("f4_drop", bv, bs, bd, be, 8, 1, 1, 0);
    bv = n_valid; bs = n_fs; bd = n_fd; be = n_le;
    frame_begin(1'b0);
    send_line(8, 1'b0);
    frame_end();
    check_counts("f5_off", bv, bs, bd, be, 0, 0, 0, 0);

    // Reset mid-line, then bytes without a new vsync must be ignored.
    bv = n_valid; bs = n_fs; bd = n_fd; be = n_le;
    frame_begin(1'b1);
    exp_on = 1'b0;
    begin
      exp_pix_t e;
      e.x = 3'd0; e.y = 2'd0;
      e.r_hi = {byte_at(bf, 0, 0), byte_at(bf, 0, 1)};
      e.r_lo = {byte_at(bf, 0, 1), byte_at(bf, 0, 0)};
      q.push_back(e);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, byte_at(bf, 0, k));
    rst = 1'b1;
    cyc(1'b0, 1'b1, 8'h5A);
    check_zero("mid_reset_outputs");
    rst = 1'b0;
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 8'(8'hA0 + k));
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_counts("rst_mid", bv, bs, bd, be, 1, 1, 0, 0);

    // Capture resumes after a full vsync high/fall.
    bv = n_valid; bs = n_fs; bd = n_fd; be = n_le;
    frame_begin(1'b1);
    send_line(8, 1'b0);
    frame_end();
    check_counts("after_rst", bv, bs, bd, be, 4, 1, 1, 0);

    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    check_val("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
